spi_rx: RTL and testbench
=========================

Name: spi_rx

Overview:
- Receive-side shift stage of the APB-to-SPI master, parallel to the TX stage.
- Samples the serial input line on each receive strobe from the SPI clock generator, and assembles bits into WORD_W-bit words.
- Hands each word to the APB/RX-FIFO side over a valid/ready handshake.
- Reports frame completion and sticky overrun.

Parameters:
- WORD_W, 32, width of one assembled word; must be a power of 2, at least 8.
- CNT_W, 16, width of the bit counter and length registers.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- en_i  input  1  receive enable; sampled only in IDLE
- rx_edge_i  input  1  one-cycle strobe marking the SCLK sampling edge
- sdi_i  input  1  serial data in (MISO), already synchronised
- rx_length_i  input  CNT_W  frame length in bits
- rx_length_updt_i  input  1  load rx_length_i into the target register
- rx_done_o  output  1  one-cycle pulse on the last bit of the frame
- rx_data_o  output  WORD_W  assembled word
- rx_data_vld_o  output  1  rx_data_o holds an unconsumed word
- rx_data_rdy_i  input  1  consumer accepts the word
- rx_overrun_o  output  1  sticky: a completed word was dropped
- rx_overrun_clr_i  input  1  clears rx_overrun_o
- rx_busy_o  output  1  FSM in RECEIVE

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high; the module has one clock and no asynchronous logic.
- Reset values:
  - FSM = IDLE.
  - Target length = 0, bit counter = 0, shift register = 0.
  - rx_data_o = 0, rx_data_vld_o = 0, rx_overrun_o = 0, rx_done_o = 0, rx_busy_o = 0.
- Reset mid-frame discards the partial word and any buffered word.
- Target length:
  - Loaded on rx_length_updt_i in any state.
  - Length 0 means 2^CNT_W bits (counter compare is modulo 2^CNT_W: last bit when cnt == trgt-1).
- FSM states:
  - IDLE -> RECEIVE when en_i=1. The same cycle clears the bit counter and the shift register.
  - RECEIVE -> IDLE on the cycle rx_done_o fires.
  - en_i is ignored in RECEIVE; a frame always runs to its length.
- Bit capture, in RECEIVE with rx_edge_i=1:
  - shift = {shift[WORD_W-2:0], sdi_i} (MSB first).
  - cnt increments.
  - rx_edge_i in IDLE is ignored.
- Word completion, on the sampling edge where cnt[log2(WORD_W)-1:0] == all ones, or the last bit of the frame:
  - The word is {shift[WORD_W-2:0], sdi_i}.
  - A partial final word of k bits is right-aligned: bits [k-1:0] hold the data, upper bits are 0.
  - The shift register clears for the next word.
- Output buffer (single entry):
  - Completed word loads rx_data_o and sets rx_data_vld_o the next cycle, i.e. 1 clk after the completing edge.
  - Load is allowed if vld=0, or vld=1 and rx_data_rdy_i=1 in the same cycle. Pop and push together: new word replaces old, vld stays 1.
  - Otherwise the new word is dropped, rx_data_o is kept, and rx_overrun_o is set.
  - vld clears on vld&rdy with no simultaneous push.
  - rx_data_o is stable while vld=1 and not popped.
- Overrun flag:
  - Set and clear in the same cycle: set wins.
  - Flag persists across frames until cleared or reset.
- rx_done_o:
  - Combinational: (state==RECEIVE) & rx_edge_i & (cnt == trgt-1).
  - Asserts together with the final word completion.
- rx_busy_o = (state==RECEIVE).

Optional Feature:
- Macro SPI_RX_LSB_FIRST_EN.
- Defined:
  - Shift right: shift = {sdi_i, shift[WORD_W-1:1]}, so the first bit lands in bit 0 of a full word.
  - A partial final word of k bits is right-justified: shifted right by WORD_W-k at completion so the first bit is in bit 0; upper bits are 0.
- Undefined: MSB-first behaviour as above.

Test Plan:
- Length 32, sdi pattern 0xA5C3_0F81 MSB first, rdy=1 -> one vld pulse with rx_data_o=0xA5C3_0F81; rx_done_o pulses on the 32nd edge; FSM returns to IDLE.
- Length 40, bits 0xDEADBEEF then 0xB4 -> words 0xDEADBEEF and 0x000000B4; rx_done_o pulses once, on the 40th edge.
- Length 96, rdy held 0 -> first word kept in rx_data_o; rx_overrun_o=1 after the 64th edge; rx_overrun_clr_i pulse -> 0.
- rdy=1 on the same cycle a new word completes with vld=1 -> new word replaces old, vld stays 1, no overrun.
- rst_i asserted at bit 17 of a 32-bit frame -> all outputs 0 next cycle; a new frame with en_i receives correctly from bit 0.
- Length 0 -> frame runs 65536 edges (2048 words); rx_done_o on the last edge only. With SPI_RX_LSB_FIRST_EN, repeat scenario 1 and expect the bit-reversed word 0x81F0_C3A5.

Source files
------------

// File: rtl/spi_rx.sv
// ---------------------------------------------------------------------------
// spi_rx - receive-side shift stage of the APB-to-SPI master.
//
// Samples sdi_i on every rx_edge_i strobe while receiving and packs the bits
// into WORD_W-bit words. Each completed word goes into a single-entry output
// buffer that the consumer drains over a valid/ready handshake. If the buffer
// is still full when a word completes, that word is dropped and a sticky
// overrun flag is raised.
//
// Build option:
//   SPI_RX_LSB_FIRST_EN  when defined, bits are packed LSB first, so the first
//                        received bit lands in bit 0. A short final word is
//                        right-justified. When undefined, bits are packed MSB
//                        first.
//
// Ports:
//   clk_i             system clock
//   rst_i             synchronous reset, active-high
//   en_i              start a frame (sampled in IDLE only)
//   rx_edge_i         one-cycle SCLK sampling strobe
//   sdi_i             serial data in (already synchronised)
//   rx_length_i       frame length in bits (0 = 2^CNT_W)
//   rx_length_updt_i  load rx_length_i into the target length register
//   rx_done_o         pulse on the last bit of the frame
//   rx_data_o         assembled word
//   rx_data_vld_o     rx_data_o holds an unconsumed word
//   rx_data_rdy_i     consumer accepts the word
//   rx_overrun_o      sticky: a completed word was dropped
//   rx_overrun_clr_i  clears rx_overrun_o
//   rx_busy_o         frame in progress
// ---------------------------------------------------------------------------
module spi_rx #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              rx_edge_i,
    input  logic              sdi_i,
    input  logic [CNT_W-1:0]  rx_length_i,
    input  logic              rx_length_updt_i,
    output logic              rx_done_o,
    output logic [WORD_W-1:0] rx_data_o,
    output logic              rx_data_vld_o,
    input  logic              rx_data_rdy_i,
    output logic              rx_overrun_o,
    input  logic              rx_overrun_clr_i,
    output logic              rx_busy_o
);

    localparam int LW = $clog2(WORD_W);

    typedef enum logic {
        S_IDLE,
        S_RECEIVE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_trgt;
    logic [CNT_W-1:0]    r_cnt;
    // One bit narrower than a word: the bit that would fall out of the top
    // (or bottom) is always zero because the word completes and clears first.
    logic [WORD_W-2:0]   r_shift;

    logic                w_capture;
    logic                w_last;
    logic                w_word_end;
    logic [WORD_W-1:0]   w_word_full;
    logic [WORD_W-2:0]   w_shift_nxt;
    logic [WORD_W-1:0]   w_word;
    logic                w_drop;

    assign w_capture  = (r_state == S_RECEIVE) && rx_edge_i;
    // Modulo compare: a target of 0 wraps to all ones, i.e. 2^CNT_W bits.
    assign w_last     = (r_cnt == (r_trgt - CNT_W'(1)));
    assign w_word_end = w_capture && ((&r_cnt[LW-1:0]) || w_last);

`ifdef SPI_RX_LSB_FIRST_EN
    logic [LW-1:0] w_pad;

    assign w_word_full = {sdi_i, r_shift};
    assign w_shift_nxt = w_word_full[WORD_W-1:1];
    // A word of k = cnt_low+1 bits sits in the top k bits; shift it down by
    // WORD_W-k = ~cnt_low so the first bit ends up in bit 0.
    assign w_pad       = ~r_cnt[LW-1:0];
    assign w_word      = w_word_full >> w_pad;
`else
    assign w_word_full = {r_shift, sdi_i};
    assign w_shift_nxt = w_word_full[WORD_W-2:0];
    // The shift register starts each word at zero, so a short final word is
    // already right-aligned.
    assign w_word      = w_word_full;
`endif

    assign w_drop    = w_word_end && rx_data_vld_o && !rx_data_rdy_i;
    assign rx_done_o = w_capture && w_last;
    assign rx_busy_o = (r_state == S_RECEIVE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_trgt        <= '0;
            r_cnt         <= '0;
            r_shift       <= '0;
            rx_data_o     <= '0;
            rx_data_vld_o <= 1'b0;
            rx_overrun_o  <= 1'b0;
        end else begin
            if (rx_length_updt_i) begin
                r_trgt <= rx_length_i;
            end

            case (r_state)
                S_IDLE: begin
                    if (en_i) begin
                        r_state <= S_RECEIVE;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                S_RECEIVE: begin
                    if (rx_edge_i) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_shift <= w_word_end ? '0 : w_shift_nxt;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Single-entry buffer: a push may replace a word popped the same cycle.
            if (w_word_end) begin
                if (!rx_data_vld_o || rx_data_rdy_i) begin
                    rx_data_o     <= w_word;
                    rx_data_vld_o <= 1'b1;
                end
            end else if (rx_data_vld_o && rx_data_rdy_i) begin
                rx_data_vld_o <= 1'b0;
            end

            // Clear first so a simultaneous drop wins.
            if (rx_overrun_clr_i) begin
                rx_overrun_o <= 1'b0;
            end
            if (w_drop) begin
                rx_overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
module tb_spi_rx;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rx_edge;
    logic          sdi;
    logic [CW-1:0] len;
    logic          updt;
    logic          rdy;
    logic          clr;
    logic          rx_done_o;
    logic [W-1:0]  rx_data_o;
    logic          rx_data_vld_o;
    logic          rx_overrun_o;
    logic          rx_busy_o;

    spi_rx #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_i             (en),
        .rx_edge_i        (rx_edge),
        .sdi_i            (sdi),
        .rx_length_i      (len),
        .rx_length_updt_i (updt),
        .rx_done_o        (rx_done_o),
        .rx_data_o        (rx_data_o),
        .rx_data_vld_o    (rx_data_vld_o),
        .rx_data_rdy_i    (rdy),
        .rx_overrun_o     (rx_overrun_o),
        .rx_overrun_clr_i (clr),
        .rx_busy_o        (rx_busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: frame progress as a bit index, buffer as plain flags.
    bit          fb [0:65535];
    bit          m_busy;
    bit          m_vld;
    bit          m_ovr;
    logic [W-1:0] m_data;
    int          m_n;
    int          m_N;

    bit          got_first;
    logic [W-1:0] first_data;
    int          done_cnt;

    typedef struct {
        int           len;
        logic [127:0] pat;
        int           mode;   // 0: rdy low, 1: rdy high, 2: rdy only on word-completing edges
        logic [W-1:0] first;
        logic [W-1:0] last;
        bit           vld;
        bit           ovr;
    } vec_t;

    vec_t tv [4];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word ending at bit index e, built from the bits of that word alone.
    function automatic logic [W-1:0] model_word(input int e);
        int s;
        logic [W-1:0] w;
        s = e - (e % W);
        w = '0;
        for (int j = s; j <= e; j++) begin
`ifdef SPI_RX_LSB_FIRST_EN
            w[j-s] = fb[j];
`else
            w = {w[W-2:0], fb[j]};
`endif
        end
        return w;
    endfunction

    function automatic bit rdy_for(input int mode, input bit is_edge, input int i, input int n);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return is_edge && (((i % W) == W-1) || (i == n-1));
            default: return ($urandom_range(0, 99) < 60);
        endcase
    endfunction

    function automatic bit clr_for(input int mode);
        return (mode == 3) && ($urandom_range(0, 99) < 10);
    endfunction

    task automatic cycle(input bit e_edge, input bit s, input bit e_en, input bit r, input bit c);
        bit exp_done;
        bit push;
        bit drop;
        logic [W-1:0] word;
        rx_edge = e_edge;
        sdi     = s;
        en      = e_en;
        rdy     = r;
        clr     = c;
        #1;
        exp_done = m_busy && e_edge && (m_n == m_N - 1);
        chk("rx_done", rx_done_o, exp_done);
        if (rx_done_o) done_cnt++;
        push = 0;
        drop = 0;
        word = '0;
        if (!m_busy) begin
            if (e_en) begin
                m_busy = 1;
                m_n    = 0;
            end
        end else if (e_edge) begin
            if ((((m_n + 1) % W) == 0) || (m_n + 1 == m_N)) begin
                push = 1;
                word = model_word(m_n);
            end
            if (m_n + 1 == m_N) m_busy = 0;
            m_n++;
        end
        if (push) begin
            if (!m_vld || r) begin
                m_data = word;
                m_vld  = 1;
            end else begin
                drop = 1;
            end
        end else if (m_vld && r) begin
            m_vld = 0;
        end
        if (c) m_ovr = 0;
        if (drop) m_ovr = 1;
        if (updt) m_N = (len == 0) ? 65536 : int'(len);
        @(posedge clk);
        #1;
        chk("rx_busy", rx_busy_o, m_busy);
        chk("rx_vld", rx_data_vld_o, m_vld);
        chk("rx_overrun", rx_overrun_o, m_ovr);
        if (m_vld) chk("rx_data", rx_data_o, m_data);
        if (rx_data_vld_o && !got_first) begin
            got_first  = 1;
            first_data = rx_data_o;
        end
    endtask

    task automatic run_frame(input int lenv, input logic [127:0] pat, input bit use_pat,
                             input int mode, input int gap_max, input int stop_at);
        int n;
        int g;
        n = (lenv == 0) ? 65536 : lenv;
        for (int i = 0; i < n; i++) begin
            if (use_pat) fb[i] = pat[n-1-i];
            else         fb[i] = 1'($urandom_range(0, 1));
        end
        len  = CW'(lenv);
        updt = 1;
        cycle(0, 0, 0, rdy_for(mode, 0, 0, n), clr_for(mode));
        updt = 0;
        if (mode == 3) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++)
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                      rdy_for(mode, 0, 0, n), clr_for(mode));
        end
        cycle(0, 0, 1, rdy_for(mode, 0, 0, n), clr_for(mode));
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) return;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int k = 0; k < g; k++)
                cycle(0, 1'($urandom_range(0, 1)), (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0,
                      rdy_for(mode, 0, i, n), clr_for(mode));
            cycle(1, fb[i], (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0,
                  rdy_for(mode, 1, i, n), clr_for(mode));
        end
    endtask

    task automatic drain();
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        got_first = 0;
        done_cnt  = 0;
    endtask

    task automatic do_reset();
        rst     = 1;
        rx_edge = 1;
        en      = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("rst_vld", rx_data_vld_o, 0);
        chk("rst_data", rx_data_o, 0);
        chk("rst_overrun", rx_overrun_o, 0);
        chk("rst_busy", rx_busy_o, 0);
        chk("rst_done", rx_done_o, 0);
        rx_edge = 0;
        en      = 0;
        m_busy = 0; m_vld = 0; m_ovr = 0; m_data = '0; m_n = 0; m_N = 65536;
    endtask

    initial begin
`ifdef SPI_RX_LSB_FIRST_EN
        tv[0] = '{32, 128'hA5C3_0F81, 1, 32'h81F0_C3A5, 32'h81F0_C3A5, 1, 0};
        tv[1] = '{40, 128'hDE_ADBE_EFB4, 1, 32'hF77D_B57B, 32'h0000_002D, 1, 0};
        tv[2] = '{96, 128'hDEAD_BEEF_A5C3_0F81_1234_5678, 0, 32'hF77D_B57B, 32'hF77D_B57B, 1, 1};
        tv[3] = '{64, 128'hDEAD_BEEF_A5C3_0F81, 2, 32'hF77D_B57B, 32'h81F0_C3A5, 1, 0};
`else
        tv[0] = '{32, 128'hA5C3_0F81, 1, 32'hA5C3_0F81, 32'hA5C3_0F81, 1, 0};
        tv[1] = '{40, 128'hDE_ADBE_EFB4, 1, 32'hDEAD_BEEF, 32'h0000_00B4, 1, 0};
        tv[2] = '{96, 128'hDEAD_BEEF_A5C3_0F81_1234_5678, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1};
        tv[3] = '{64, 128'hDEAD_BEEF_A5C3_0F81, 2, 32'hDEAD_BEEF, 32'hA5C3_0F81, 1, 0};
`endif
        rst = 1; en = 0; rx_edge = 0; sdi = 0; len = '0; updt = 0; rdy = 0; clr = 0;
        got_first = 0; done_cnt = 0;
        @(posedge clk);
        do_reset();

        for (int k = 0; k < 4; k++) begin
            drain();
            run_frame(tv[k].len, tv[k].pat, 1, tv[k].mode, 1, -1);
            chk("tv_done_cnt", done_cnt, 1);
            chk("tv_first", first_data, tv[k].first);
            chk("tv_last", rx_data_o, tv[k].last);
            chk("tv_vld", rx_data_vld_o, tv[k].vld);
            chk("tv_ovr", rx_overrun_o, tv[k].ovr);
            chk("tv_idle", rx_busy_o, 0);
            if (tv[k].ovr) begin
                cycle(0, 0, 0, 0, 1);
                chk("ovr_clr", rx_overrun_o, 0);
            end
        end

        // Reset mid-frame with a buffered word pending.
        drain();
        run_frame(32, 128'h0F0F_F0F0, 1, 0, 0, -1);
        run_frame(32, 128'hFFFF_FFFF, 1, 0, 0, 17);
        do_reset();
        got_first = 0;
        done_cnt  = 0;
        run_frame(32, 128'h1234_5678, 1, 1, 0, -1);
`ifdef SPI_RX_LSB_FIRST_EN
        chk("after_rst_word", first_data, 32'h1E6A_2C48);
`else
        chk("after_rst_word", first_data, 32'h1234_5678);
`endif
        chk("after_rst_done_cnt", done_cnt, 1);

        // Randomised frames: random lengths, strobe gaps, rdy, clear and en noise.
        for (int f = 0; f < 12; f++) begin
            done_cnt = 0;
            run_frame($urandom_range(1, 100), '0, 0, 3, 2, -1);
            chk("rand_done_cnt", done_cnt, 1);
        end

        // Length 0 wraps to 65536 bits.
        drain();
        run_frame(0, '0, 0, 1, 0, -1);
        chk("len0_done_cnt", done_cnt, 1);
        chk("len0_idle", rx_busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
